// File: rtl/d_memory_ws.sv
// Wait-state data memory: 32-bit words with big-endian byte/half lanes and a fixed access latency.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned/illegal-size accesses instead of aligning them down.
module d_memory_ws #(
    parameter int ADDRWIDTH   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_req,
    input  logic                 mem_write,
    input  logic [1:0]           mem_size,
    input  logic                 mem_unsigned,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 mem_ready,
    output logic                 mem_busy,
    output logic                 addr_error
);

    // state | meaning
    // IDLE  | waiting for a request
    // BUSY  | wait states counting down; access executes when counter is 0
    // RESP  | completion cycle (mem_ready high); may accept the next request
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int DEPTH = 1 << (ADDRWIDTH - 2);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [1:0]           size_q;
    logic                 write_q;
    logic                 unsigned_q;
    logic [31:0]          wdata_q;
    logic                 err_q;

    logic                 accept;
    logic                 execute;
    logic                 misaligned;

    logic [31:0]          mem [0:DEPTH-1];
    logic [ADDRWIDTH-3:0] word_idx;
    logic [1:0]           eff_size;
    logic [31:0]          cur_word;
    logic [31:0]          store_word;
    logic [31:0]          load_val;
    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = (mem_size == 2'b11) ||
                        (mem_size == 2'b01 && addr[0]) ||
                        (mem_size == 2'b10 && addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        execute = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (mem_req) begin
                    accept = 1'b1;
                    if (misaligned) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    execute = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept)
                err_q <= misaligned;
            if (execute && !write_q)
                read_data <= load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q     <= addr;
            size_q     <= mem_size;
            write_q    <= mem_write;
            unsigned_q <= mem_unsigned;
            wdata_q    <= write_data;
        end
    end

    // Size 11 only reaches execution when trapping is off, where it behaves as a word.
    assign eff_size = (size_q == 2'b11) ? 2'b10 : size_q;
    assign word_idx = addr_q[ADDRWIDTH-1:2];
    assign cur_word = mem[word_idx];

    always_comb begin
        store_word = cur_word;
        load_val   = cur_word;
        sel_byte   = 8'd0;
        sel_half   = 16'd0;
        case (eff_size)
            2'b00: begin
                case (addr_q[1:0])
                    2'b00: begin store_word[31:24] = wdata_q[7:0]; sel_byte = cur_word[31:24]; end
                    2'b01: begin store_word[23:16] = wdata_q[7:0]; sel_byte = cur_word[23:16]; end
                    2'b10: begin store_word[15:8]  = wdata_q[7:0]; sel_byte = cur_word[15:8];  end
                    default: begin store_word[7:0] = wdata_q[7:0]; sel_byte = cur_word[7:0];   end
                endcase
                load_val = {{24{~unsigned_q & sel_byte[7]}}, sel_byte};
            end
            2'b01: begin
                if (addr_q[1]) begin
                    store_word[15:0] = wdata_q[15:0];
                    sel_half         = cur_word[15:0];
                end else begin
                    store_word[31:16] = wdata_q[15:0];
                    sel_half          = cur_word[31:16];
                end
                load_val = {{16{~unsigned_q & sel_half[15]}}, sel_half};
            end
            default: store_word = wdata_q;
        endcase
    end

    // Memory has no reset; a reset on the execute edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && execute && write_q)
            mem[word_idx] <= store_word;
    end

    assign mem_ready  = (state_q == RESP);
    assign mem_busy   = (state_q == BUSY);
    assign addr_error = (state_q == RESP) && err_q;

endmodule
